// File: rtl/riscv_muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
//   muldiv_op_e    : RV32M funct3 codes
//   muldiv_state_e : sequencer states
//   MULDIV_ITERS   : shift-add / restoring iterations per operation
package riscv_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int ADDR_WIDTH   = 5;
  localparam int MULDIV_ITERS = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/riscv_muldiv_if.sv
// Request / writeback bundle between the pipeline and the mul/div unit.
//   master : pipeline side (drives request, kill; sees busy and write port)
//   slave  : mul/div unit side
interface riscv_muldiv_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  start;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  kill;
  logic                  busy;
  logic                  done;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output start, op, rs1_data, rs2_data, rd_addr, kill,
    input  busy, done, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  start, op, rs1_data, rs2_data, rd_addr, kill,
    output busy, done, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/riscv_muldiv_sign.sv
// Combinational sign handling for the mul/div unit.
//   op, rs1_data, rs2_data -> a_mag/b_mag operand magnitudes, a_neg/b_neg
//                             (operand negative and treated as signed)
//   fix_is_mul, fix_a_neg, fix_b_neg, acc -> fixed: sign-corrected
//     64-bit product, or {remainder, quotient} for divides
module riscv_muldiv_sign
  import riscv_pkg::*;
(
  input  muldiv_op_e  op,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [31:0] a_mag,
  output logic [31:0] b_mag,
  output logic        a_neg,
  output logic        b_neg,
  input  logic        fix_is_mul,
  input  logic        fix_a_neg,
  input  logic        fix_b_neg,
  input  logic [63:0] acc,
  output logic [63:0] fixed
);

  logic signed_a;
  logic signed_b;
  logic differ;

  // NOTE: every output of a combinational block gets a default first, so
  // no path through the block leaves a value held and a latch is inferred.
  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    // MUL's low word is the same for any signedness, so treat it as signed.
    unique case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        signed_a = 1'b1;
        signed_b = 1'b1;
      end
      OP_MULHSU: signed_a = 1'b1;
      default: ;
    endcase
    a_neg = signed_a & rs1_data[31];
    b_neg = signed_b & rs2_data[31];
    a_mag = a_neg ? (~rs1_data + 32'd1) : rs1_data;
    b_mag = b_neg ? (~rs2_data + 32'd1) : rs2_data;
  end

  always_comb begin
    differ = fix_a_neg ^ fix_b_neg;
    fixed  = acc;
    if (fix_is_mul) begin
      if (differ) fixed = ~acc + 64'd1;
    end else begin
      // Remainder follows the dividend; quotient follows the sign product.
      fixed[63:32] = fix_a_neg ? (~acc[63:32] + 32'd1) : acc[63:32];
      fixed[31:0]  = differ    ? (~acc[31:0]  + 32'd1) : acc[31:0];
    end
  end

endmodule

// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide unit with a register-file write port.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of riscv_muldiv_if (request, kill, busy,
//              done pulse, wr_en/wr_addr/wr_data write request)
// A request runs 32 shift-add or restoring-divide iterations, one sign-fix
// cycle, then one write cycle. Divide-by-zero and signed overflow skip
// straight to the write cycle with the architectural result preloaded.
module riscv_muldiv
  import riscv_pkg::*;
(
  input logic           clk,
  input logic           rst,
  riscv_muldiv_if.slave bus
);

  muldiv_state_e state;
  muldiv_op_e    op_q;
  logic [4:0]    rd_q;
  logic [31:0]   divisor;    // multiplicand or divisor magnitude
  logic          a_neg_q;
  logic          b_neg_q;
  logic [63:0]   acc;        // {hi,lo} product or {rem,quo}
  logic [5:0]    cnt;
  logic [31:0]   result;
  logic          done_q;
  logic          wr_en_q;
  logic [4:0]    wr_addr_q;
  logic [31:0]   wr_data_q;

  muldiv_op_e  op_in;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        a_neg;
  logic        b_neg;
  logic [63:0] fixed;
  logic        div_zero;
  logic        overflow;
  logic [31:0] special_res;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] rem_sh;
  logic [31:0] rem_sub;
  logic [63:0] div_next;
  logic        is_div_q;
  logic        sel_hi;

  assign op_in    = muldiv_op_e'(bus.op);
  assign is_div_q = op_q[2];

  riscv_muldiv_sign u_sign (
    .op         (op_in),
    .rs1_data   (bus.rs1_data),
    .rs2_data   (bus.rs2_data),
    .a_mag      (a_mag),
    .b_mag      (b_mag),
    .a_neg      (a_neg),
    .b_neg      (b_neg),
    .fix_is_mul (~is_div_q),
    .fix_a_neg  (a_neg_q),
    .fix_b_neg  (b_neg_q),
    .acc        (acc),
    .fixed      (fixed)
  );

  // Early-out cases resolved at request time.
  always_comb begin
    div_zero = bus.op[2] && (bus.rs2_data == 32'd0);
    overflow = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
               (bus.rs1_data == 32'h8000_0000) && (bus.rs2_data == 32'hFFFF_FFFF);
    if (bus.op[1]) special_res = div_zero ? bus.rs1_data : 32'd0;
    else           special_res = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
  end

  // One iteration step for each datapath.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + {1'b0, divisor};
    mul_next = acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:1]};
    // The shifted partial remainder needs 33 bits before the compare.
    rem_sh   = acc[63:31];
    rem_sub  = rem_sh[31:0] - divisor;
    if (rem_sh >= {1'b0, divisor}) div_next = {rem_sub,      acc[30:0], 1'b1};
    else                           div_next = {rem_sh[31:0], acc[30:0], 1'b0};
    sel_hi   = (op_q != OP_MUL) && (op_q != OP_DIV) && (op_q != OP_DIVU);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= OP_MUL;
      rd_q      <= '0;
      divisor   <= '0;
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      result    <= '0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.start && !bus.kill) begin
            op_q    <= op_in;
            rd_q    <= bus.rd_addr;
            divisor <= b_mag;
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
            acc     <= {32'd0, a_mag};
            cnt     <= '0;
            if (div_zero || overflow) begin
              result <= special_res;
              state  <= ST_DONE;
            end else begin
              state  <= ST_ITER;
            end
          end
        end
        ST_ITER: begin
          if (bus.kill) begin
            state <= ST_IDLE;
          end else begin
            acc <= is_div_q ? div_next : mul_next;
            cnt <= cnt + 6'd1;
            if (cnt == 6'(MULDIV_ITERS - 1)) state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (bus.kill) begin
            state <= ST_IDLE;
          end else begin
            result <= sel_hi ? fixed[63:32] : fixed[31:0];
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          if (!bus.kill) begin
            done_q    <= 1'b1;
            wr_en_q   <= (rd_q != 5'd0);
            wr_addr_q <= rd_q;
            wr_data_q <= result;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy    = (state != ST_IDLE);
  assign bus.done    = done_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Self-checking bench for riscv_muldiv: directed RV32M cases, early-out
// cases, ignored start, kill and reset mid-operation, then random ops
// checked against an arithmetic reference model.
module tb_riscv_muldiv;

  logic clk = 1'b0;
  logic rst;
  int   checks_total  = 0;
  int   checks_passed = 0;

  riscv_muldiv_if bus ();

  riscv_muldiv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: RV32M semantics computed with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ua;
    longint      ub;
    longint      r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    r  = 0;
    case (op)
      3'd0: r = sa * sb;
      3'd1: r = (sa * sb) >>> 32;
      3'd2: r = (sa * ub) >>> 32;
      3'd3: begin u = {32'd0, a} * {32'd0, b}; r = longint'(u >> 32); end
      3'd4: r = (b == 0) ? -1 : sa / sb;
      3'd5: r = (b == 0) ? -1 : ua / ub;
      3'd6: r = (b == 0) ? sa : sa % sb;
      default: r = (b == 0) ? ua : ua % ub;
    endcase
    return r[31:0];
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && b == 32'd0) return 2;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 35;
  endfunction

  // Issue one request and watch a fixed 40-cycle window. hold keeps start
  // asserted (with scrambled operands) for that many cycles after E0.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_data, input int hold);
    int          lat;
    int          done_n;
    int          wr_n;
    int          busy_n;
    int          done_at;
    logic [31:0] got_data;
    logic [4:0]  got_addr;
    lat      = ref_latency(op, a, b);
    done_n   = 0;
    wr_n     = 0;
    busy_n   = 0;
    done_at  = -1;
    got_data = 'x;
    got_addr = 'x;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.op       = op;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.rd_addr  = rd;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.wr_en) wr_n++;
      if (bus.done) begin
        done_n++;
        done_at  = n;
        got_data = bus.wr_data;
        got_addr = bus.wr_addr;
      end
      if (n > hold) bus.start = 1'b0;
      bus.op       = 3'($urandom_range(0, 7));
      bus.rs1_data = $urandom;
      bus.rs2_data = $urandom;
      bus.rd_addr  = 5'($urandom_range(0, 31));
    end
    check({tag, " done_count"}, 64'(done_n), 64'd1);
    check({tag, " latency"}, 64'(done_at), 64'(lat));
    check({tag, " wr_data"}, {32'd0, got_data}, {32'd0, exp_data});
    check({tag, " wr_addr"}, {59'd0, got_addr}, {59'd0, rd});
    check({tag, " wr_en_count"}, 64'(wr_n), (rd != 5'd0) ? 64'd1 : 64'd0);
    check({tag, " busy_cycles"}, 64'(busy_n), 64'(lat - 1));
  endtask

  // Start an op, then assert kill or rst at cycle k after E0.
  task automatic abort_op(input string tag, input bit use_rst, input int k);
    int done_n;
    int wr_n;
    done_n = 0;
    wr_n   = 0;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.op       = 3'd4;
    bus.rs1_data = 32'd1000;
    bus.rs2_data = 32'd3;
    bus.rd_addr  = 5'd9;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) done_n++;
      if (bus.wr_en) wr_n++;
      if (n == k) begin
        if (use_rst) rst = 1'b1;
        else         bus.kill = 1'b1;
      end
      if (n == k + 1) begin
        bus.kill = 1'b0;
        rst      = 1'b0;
        check({tag, " busy_after"}, {63'd0, bus.busy}, 64'd0);
        if (use_rst) begin
          check({tag, " wr_addr_reset"}, {59'd0, bus.wr_addr}, 64'd0);
          check({tag, " wr_data_reset"}, {32'd0, bus.wr_data}, 64'd0);
        end
      end
    end
    check({tag, " no_done"}, 64'(done_n), 64'd0);
    check({tag, " no_write"}, 64'(wr_n), 64'd0);
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_rd;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.kill     = 1'b0;
    bus.op       = 3'd0;
    bus.rs1_data = 32'd0;
    bus.rs2_data = 32'd0;
    bus.rd_addr  = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy",    {63'd0, bus.busy},    64'd0);
    check("reset done",    {63'd0, bus.done},    64'd0);
    check("reset wr_en",   {63'd0, bus.wr_en},   64'd0);
    check("reset wr_addr", {59'd0, bus.wr_addr}, 64'd0);
    check("reset wr_data", {32'd0, bus.wr_data}, 64'd0);
    rst = 1'b0;

    run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 0);
    run_op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, 0);
    run_op("mulhu",  3'd3, 32'h8000_0000,  32'h8000_0000, 5'd7,  32'h4000_0000, 0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 0);
    run_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFD, 0);
    run_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         5'd11, 32'hFFFF_FFFF, 0);
    run_op("divu",   3'd5, 32'd100,        32'd7,         5'd12, 32'd14,        0);
    run_op("remu",   3'd7, 32'd100,        32'd7,         5'd13, 32'd2,         0);
    run_op("div0",   3'd4, 32'd5,          32'd0,         5'd14, 32'hFFFF_FFFF, 0);
    run_op("rem0",   3'd6, 32'd5,          32'd0,         5'd15, 32'd5,         0);
    run_op("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 0);
    run_op("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd17, 32'd0,         0);
    run_op("rd0",    3'd0, 32'd3,          32'd4,         5'd0,  32'd12,        0);
    run_op("hold",   3'd5, 32'd1000,       32'd10,        5'd18, 32'd100,       12);

    abort_op("kill", 1'b0, 10);
    run_op("after_kill", 3'd0, 32'd9, 32'd9, 5'd19, 32'd81, 0);
    abort_op("rst", 1'b1, 20);
    run_op("after_rst", 3'd7, 32'd17, 32'd5, 5'd20, 32'd2, 0);

    for (int i = 0; i < 12; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (i == 3) r_b = 32'($urandom_range(1, 15));
      if (i == 7) begin r_op = 3'd4; r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
      r_rd = 5'($urandom_range(0, 31));
      run_op($sformatf("rand%0d_op%0d", i, r_op), r_op, r_a, r_b, r_rd,
             ref_result(r_op, r_a, r_b), 0);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/riscv_muldiv.md
# riscv_muldiv

Iterative RV32M multiply/divide unit placed between operand read and writeback. It takes both source operands as read from the register file, runs a 32-iteration shift-add multiply or restoring divide, and issues the result as a single-cycle write request on the register file's write port (wr_en/wr_addr/wr_data). Integer ALU operations bypass it; the pipeline stalls on `busy`.

## Interface
- DATA_WIDTH, 32, operand/result width (only 32 is supported)
- ADDR_WIDTH, 5, destination register address width
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only in IDLE
- op  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_data  in  DATA_WIDTH  operand A (register file read port A)
- rs2_data  in  DATA_WIDTH  operand B (register file read port B)
- rd_addr  in  ADDR_WIDTH  destination register
- kill  in  1  abort the in-flight operation (pipeline flush)
- busy  out  1  operation accepted and not yet completed
- done  out  1  one-cycle completion pulse
- wr_en  out  1  register file write enable
- wr_addr  out  ADDR_WIDTH  register file write address
- wr_data  out  DATA_WIDTH  result

## Operation
- States are IDLE, ITER, FIX, and DONE.
- **IDLE**
  - If start=1: latch op, rd_addr, and the operand magnitudes, plus the sign flags selected by op. MULHSU treats rs2 as unsigned. The U-variants treat both operands as unsigned.
  - Set the iteration counter to 0 and go to ITER.
  - Exception: a divide with rs2_data==0, or a signed divide with rs1=0x80000000 and rs2=0xFFFFFFFF, goes directly to DONE with the result preloaded.
- **ITER** runs for exactly 32 cycles. The counter is 6 bits and leaves ITER when it reaches 31.
  - Multiply: 64-bit accumulator. Each cycle, add the multiplicand to the upper half when the accumulator LSB is 1, then shift right by 1.
  - Divide: restoring. Shift {rem,quo} left by 1; if rem ≥ divisor, subtract the divisor and set the quotient LSB.
- **FIX** runs for one cycle.
  - Apply sign correction. The product is negated when the operand signs differ. The quotient is negated when the signs differ. The remainder takes the dividend's sign.
  - Select the result: low 32 bits for MUL, high 32 bits for MULH*, quotient for DIV*, remainder for REM*.
  - Go to DONE.
- **DONE** runs for one cycle.
  - Outputs: done=1, wr_data=result, wr_addr=latched rd_addr, wr_en=1 unless rd_addr==0.
  - Next state is IDLE.
- Special results:
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
  - Signed overflow: quotient = 0x80000000, remainder = 0.
- start while busy=1 is ignored. There is no queueing.
- kill=1 in any non-IDLE state: next state is IDLE, and no done or wr_en is produced. kill in IDLE has no effect. If kill and start are both high in IDLE, kill wins.
- rst has priority over everything. It returns the block to IDLE from any state, including mid-ITER.

## Timing
- Reset values: busy=0, done=0, wr_en=0, wr_addr=0, wr_data=0, state=IDLE, counter=0.
- Cycle numbering: start is sampled at rising edge E0.
  - Normal path: ITER spans E1–E32, FIX is at E33, and DONE state holds from E34.
  - done and wr_en are high for the one cycle between E34 and E35. Total latency is 35 cycles from request to the write.
  - Special-case path: DONE holds from E1. done is high between E1 and E2.
- busy is high from the cycle after E0 through the DONE cycle inclusive. It is 0 in the cycle after DONE, so a new start can be accepted at E35.
- done, wr_en, wr_addr, and wr_data are registered outputs. wr_data and wr_addr keep their last value outside DONE, but are valid only when done=1.
- Operands are sampled only at E0. Later changes on rs1_data, rs2_data, op, or rd_addr have no effect.

## Structure
- Shared package riscv_pkg holds:
  - `muldiv_op_e`, the enum of the 8 funct3 codes
  - `muldiv_state_e` (IDLE/ITER/FIX/DONE)
  - `MULDIV_ITERS = 32`
- One sub-module is natural: riscv_muldiv_sign. It is combinational and handles the operand absolute values and the final conditional negation.
- The iterative datapath and the FSM stay in riscv_muldiv.

## Test plan
- MUL: rs1=7, rs2=0xFFFFFFFD (−3), rd_addr=5 → at start+35, done=1, wr_en=1, wr_addr=5, wr_data=0xFFFFFFEB. busy is high for exactly 34 cycles.
- MULH/MULHU with rs1=rs2=0x80000000 → MULH gives 0x40000000. MULHU gives 0x40000000. MULHSU with rs1=0xFFFFFFFF, rs2=0xFFFFFFFF gives 0xFFFFFFFF.
- Signed divide/remainder:
  - DIV −7/2 → 0xFFFFFFFD
  - REM −7/2 → 0xFFFFFFFF
  - DIVU 100/7 → 14
  - REMU 100/7 → 2
- Divide by zero and overflow:
  - DIV 5/0 → 0xFFFFFFFF
  - REM 5/0 → 5
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000
  - REM of the same operands → 0
  - All four complete with done one cycle after the start edge.
- rd_addr=0 → done pulses and wr_en stays 0. start asserted while busy → ignored, and exactly one done is produced.
- kill at start+10 → no done, busy=0 next cycle, and a new start is accepted. rst at start+20 → all outputs at reset values after the next edge, no write.
